// File: rtl/buff_pkg.sv
// Shared constants, FSM state types and the length clamp used by the
// endpoint buffer manager and its memories.
package buff_pkg;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 8;
    localparam int LEN_W     = ADDR_W + 1;
    localparam int BUF_DEPTH = 2 ** ADDR_W;

    // IN buffer ownership: app fills it (IN_IDLE) or engine drains it (IN_FULL).
    typedef enum logic [0:0] {
        IN_IDLE = 1'b0,
        IN_FULL = 1'b1
    } in_state_t;

    // OUT buffer ownership: released, armed for engine writes, or holding a packet.
    typedef enum logic [1:0] {
        OUT_IDLE  = 2'd0,
        OUT_ARMED = 2'd1,
        OUT_FULL  = 2'd2
    } out_state_t;

    // A packet can never be longer than the buffer, so oversized lengths saturate.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len > LEN_W'(BUF_DEPTH)) begin
            return LEN_W'(BUF_DEPTH);
        end
        return len;
    endfunction

endpackage

// File: rtl/buff_dpram.sv
// 512x8 simple dual-port memory: one write port, one registered read port.
// Read data appears one clock after the address; a read of the address being
// written in the same cycle returns the old contents.
module buff_dpram
    import buff_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    // Storage array: contents are not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; cleared on reset so the output starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/buff_modport.sv
// Endpoint buffer manager between the user application and the USB packet
// engine. The IN buffer is filled by the app and drained by the engine; the
// OUT buffer is armed by the app, filled by the engine and read back by the
// app. Also provides a reset with synchronised deassertion for downstream logic.
module buff_modport
    import buff_pkg::*;
(
    input  logic              phy_ulpi_clk,
    input  logic              reset_n,
    output logic              reset_n_out,

    input  logic [ADDR_W-1:0] buf_in_addr,
    input  logic [DATA_W-1:0] buf_in_data,
    input  logic              buf_in_wren,
    output logic              buf_in_ready,
    input  logic              buf_in_commit,
    input  logic [LEN_W-1:0]  buf_in_commit_len,
    output logic              buf_in_commit_ack,

    input  logic [ADDR_W-1:0] buf_out_addr,
    output logic [DATA_W-1:0] buf_out_q,
    output logic [LEN_W-1:0]  buf_out_len,
    output logic              buf_out_hasdata,
    input  logic              buf_out_arm,
    output logic              buf_out_arm_ack,

    input  logic [ADDR_W-1:0] eng_in_rd_addr,
    output logic [DATA_W-1:0] eng_in_rd_q,
    output logic [LEN_W-1:0]  eng_in_len,
    output logic              eng_in_valid,
    input  logic              eng_in_done,

    input  logic [ADDR_W-1:0] eng_out_wr_addr,
    input  logic [DATA_W-1:0] eng_out_wr_data,
    input  logic              eng_out_wren,
    input  logic              eng_out_commit,
    input  logic [LEN_W-1:0]  eng_out_commit_len,
    output logic              eng_out_ready
);

    localparam int RAM_IN  = 0;
    localparam int RAM_OUT = 1;

    // ------------------------------------------------------------------
    // Reset output: asserts immediately, releases two clocks after reset_n.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_reg;

    // Two-flop shifter pulls a 1 in only once reset_n has been released.
    always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_reg <= '0;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign reset_n_out = rst_sync_reg[1];

    // ------------------------------------------------------------------
    // IN path FSM
    // ------------------------------------------------------------------
    in_state_t        in_state_reg, in_state_next;
    logic [LEN_W-1:0] in_len_reg,   in_len_next;
    logic             in_ack_reg,   in_ack_next;

    // IN state, committed length and acknowledge registers.
    always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
        if (!reset_n) begin
            in_state_reg <= IN_IDLE;
            in_len_reg   <= '0;
            in_ack_reg   <= 1'b0;
        end else begin
            in_state_reg <= in_state_next;
            in_len_reg   <= in_len_next;
            in_ack_reg   <= in_ack_next;
        end
    end

    // IN next state: a commit hands the buffer to the engine, done hands it back.
    always_comb begin
        in_state_next = in_state_reg;
        in_len_next   = in_len_reg;
        in_ack_next   = 1'b0;
        case (in_state_reg)
            IN_IDLE: begin
                if (buf_in_commit) begin
                    in_len_next   = clamp_len(buf_in_commit_len);
                    in_ack_next   = 1'b1;
                    in_state_next = IN_FULL;
                end
            end
            IN_FULL: begin
                if (eng_in_done) begin
                    in_state_next = IN_IDLE;
                end
            end
            default: in_state_next = IN_IDLE;
        endcase
    end

    assign buf_in_ready      = (in_state_reg == IN_IDLE);
    assign eng_in_valid      = (in_state_reg == IN_FULL);
    assign eng_in_len        = in_len_reg;
    assign buf_in_commit_ack = in_ack_reg;

    // ------------------------------------------------------------------
    // OUT path FSM
    // ------------------------------------------------------------------
    out_state_t       out_state_reg, out_state_next;
    logic [LEN_W-1:0] out_len_reg,   out_len_next;
    logic             out_ack_reg,   out_ack_next;

    // OUT state, received length and arm acknowledge registers.
    always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
        if (!reset_n) begin
            out_state_reg <= OUT_IDLE;
            out_len_reg   <= '0;
            out_ack_reg   <= 1'b0;
        end else begin
            out_state_reg <= out_state_next;
            out_len_reg   <= out_len_next;
            out_ack_reg   <= out_ack_next;
        end
    end

    // OUT next state: arm opens the buffer to the engine; an engine commit
    // takes priority over a simultaneous arm so a packet is never dropped.
    always_comb begin
        out_state_next = out_state_reg;
        out_len_next   = out_len_reg;
        out_ack_next   = 1'b0;
        case (out_state_reg)
            OUT_IDLE: begin
                if (buf_out_arm) begin
                    out_ack_next   = 1'b1;
                    out_state_next = OUT_ARMED;
                end
            end
            OUT_ARMED: begin
                if (eng_out_commit) begin
                    out_len_next   = clamp_len(eng_out_commit_len);
                    out_state_next = OUT_FULL;
                end else if (buf_out_arm) begin
                    out_ack_next   = 1'b1;
                end
            end
            OUT_FULL: begin
                if (buf_out_arm) begin
                    out_ack_next   = 1'b1;
                    out_state_next = OUT_ARMED;
                end
            end
            default: out_state_next = OUT_IDLE;
        endcase
    end

    assign eng_out_ready   = (out_state_reg == OUT_ARMED);
    assign buf_out_hasdata = (out_state_reg == OUT_FULL);
    assign buf_out_len     = out_len_reg;
    assign buf_out_arm_ack = out_ack_reg;

    // ------------------------------------------------------------------
    // Buffer memories: writes are gated by ownership of each buffer.
    // ------------------------------------------------------------------
    logic              ram_wr_en   [2];
    logic [ADDR_W-1:0] ram_wr_addr [2];
    logic [DATA_W-1:0] ram_wr_data [2];
    logic [ADDR_W-1:0] ram_rd_addr [2];
    logic [DATA_W-1:0] ram_rd_data [2];

    assign ram_wr_en[RAM_IN]    = buf_in_wren && (in_state_reg == IN_IDLE);
    assign ram_wr_addr[RAM_IN]  = buf_in_addr;
    assign ram_wr_data[RAM_IN]  = buf_in_data;
    assign ram_rd_addr[RAM_IN]  = eng_in_rd_addr;

    assign ram_wr_en[RAM_OUT]   = eng_out_wren && (out_state_reg == OUT_ARMED);
    assign ram_wr_addr[RAM_OUT] = eng_out_wr_addr;
    assign ram_wr_data[RAM_OUT] = eng_out_wr_data;
    assign ram_rd_addr[RAM_OUT] = buf_out_addr;

    assign eng_in_rd_q = ram_rd_data[RAM_IN];
    assign buf_out_q   = ram_rd_data[RAM_OUT];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ram
            buff_dpram u_ram (
                .clk     (phy_ulpi_clk),
                .rst_n   (reset_n),
                .wr_en   (ram_wr_en[gi]),
                .wr_addr (ram_wr_addr[gi]),
                .wr_data (ram_wr_data[gi]),
                .rd_addr (ram_rd_addr[gi]),
                .rd_data (ram_rd_data[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_buff_modport.sv
// Bench for buff_modport: directed scenarios plus a randomized run, all
// checked against a buffer-ownership model kept in this file.
module tb_buff_modport;

    logic       phy_ulpi_clk;
    logic       reset_n;
    logic       reset_n_out;
    logic [8:0] buf_in_addr;
    logic [7:0] buf_in_data;
    logic       buf_in_wren;
    logic       buf_in_ready;
    logic       buf_in_commit;
    logic [9:0] buf_in_commit_len;
    logic       buf_in_commit_ack;
    logic [8:0] buf_out_addr;
    logic [7:0] buf_out_q;
    logic [9:0] buf_out_len;
    logic       buf_out_hasdata;
    logic       buf_out_arm;
    logic       buf_out_arm_ack;
    logic [8:0] eng_in_rd_addr;
    logic [7:0] eng_in_rd_q;
    logic [9:0] eng_in_len;
    logic       eng_in_valid;
    logic       eng_in_done;
    logic [8:0] eng_out_wr_addr;
    logic [7:0] eng_out_wr_data;
    logic       eng_out_wren;
    logic       eng_out_commit;
    logic [9:0] eng_out_commit_len;
    logic       eng_out_ready;

    int total = 0;
    int bad   = 0;

    buff_modport dut (
        .phy_ulpi_clk       (phy_ulpi_clk),
        .reset_n            (reset_n),
        .reset_n_out        (reset_n_out),
        .buf_in_addr        (buf_in_addr),
        .buf_in_data        (buf_in_data),
        .buf_in_wren        (buf_in_wren),
        .buf_in_ready       (buf_in_ready),
        .buf_in_commit      (buf_in_commit),
        .buf_in_commit_len  (buf_in_commit_len),
        .buf_in_commit_ack  (buf_in_commit_ack),
        .buf_out_addr       (buf_out_addr),
        .buf_out_q          (buf_out_q),
        .buf_out_len        (buf_out_len),
        .buf_out_hasdata    (buf_out_hasdata),
        .buf_out_arm        (buf_out_arm),
        .buf_out_arm_ack    (buf_out_arm_ack),
        .eng_in_rd_addr     (eng_in_rd_addr),
        .eng_in_rd_q        (eng_in_rd_q),
        .eng_in_len         (eng_in_len),
        .eng_in_valid       (eng_in_valid),
        .eng_in_done        (eng_in_done),
        .eng_out_wr_addr    (eng_out_wr_addr),
        .eng_out_wr_data    (eng_out_wr_data),
        .eng_out_wren       (eng_out_wren),
        .eng_out_commit     (eng_out_commit),
        .eng_out_commit_len (eng_out_commit_len),
        .eng_out_ready      (eng_out_ready)
    );

    initial phy_ulpi_clk = 1'b0;
    always #5 phy_ulpi_clk = ~phy_ulpi_clk;

    // ---------------- reference model ----------------
    logic [7:0] m_in_mem    [512];
    bit         m_in_known  [512];
    logic [7:0] m_out_mem   [512];
    bit         m_out_known [512];
    bit         m_app_owns_in;      // 1: app may fill IN buffer
    logic [9:0] m_in_len;
    bit         m_in_ack;
    logic [7:0] m_eng_q;
    bit         m_eng_q_known;
    int         m_out_phase;        // 0 released, 1 engine may write, 2 packet waiting
    logic [9:0] m_out_len;
    bit         m_out_ack;
    logic [7:0] m_app_q;
    bit         m_app_q_known;

    task automatic model_reset();
        for (int i = 0; i < 512; i++) begin
            m_in_known[i]  = 1'b0;
            m_out_known[i] = 1'b0;
        end
        m_app_owns_in = 1'b1;
        m_in_len      = 10'd0;
        m_in_ack      = 1'b0;
        m_eng_q       = 8'h00;
        m_eng_q_known = 1'b1;
        m_out_phase   = 0;
        m_out_len     = 10'd0;
        m_out_ack     = 1'b0;
        m_app_q       = 8'h00;
        m_app_q_known = 1'b1;
    endtask

    task automatic idle_inputs();
        buf_in_addr = '0; buf_in_data = '0; buf_in_wren = 0;
        buf_in_commit = 0; buf_in_commit_len = '0;
        buf_out_addr = '0; buf_out_arm = 0;
        eng_in_rd_addr = '0; eng_in_done = 0;
        eng_out_wr_addr = '0; eng_out_wr_data = '0; eng_out_wren = 0;
        eng_out_commit = 0; eng_out_commit_len = '0;
    endtask

    // Advance the model by the inputs currently driven, then clock the DUT
    // and return 1 time unit after the edge.
    task automatic cycle();
        logic [7:0] nq;
        bit         nk;
        nq = m_in_mem[eng_in_rd_addr];
        nk = m_in_known[eng_in_rd_addr];
        m_in_ack = 1'b0;
        if (m_app_owns_in) begin
            if (buf_in_wren) begin
                m_in_mem[buf_in_addr]   = buf_in_data;
                m_in_known[buf_in_addr] = 1'b1;
            end
            if (buf_in_commit) begin
                m_in_len      = (buf_in_commit_len > 10'd512) ? 10'd512 : buf_in_commit_len;
                m_in_ack      = 1'b1;
                m_app_owns_in = 1'b0;
            end
        end else if (eng_in_done) begin
            m_app_owns_in = 1'b1;
        end
        m_eng_q = nq;
        m_eng_q_known = nk;

        nq = m_out_mem[buf_out_addr];
        nk = m_out_known[buf_out_addr];
        m_out_ack = 1'b0;
        if (m_out_phase == 1) begin
            if (eng_out_wren) begin
                m_out_mem[eng_out_wr_addr]   = eng_out_wr_data;
                m_out_known[eng_out_wr_addr] = 1'b1;
            end
            if (eng_out_commit) begin
                m_out_len   = (eng_out_commit_len > 10'd512) ? 10'd512 : eng_out_commit_len;
                m_out_phase = 2;
            end else if (buf_out_arm) begin
                m_out_ack = 1'b1;
            end
        end else if (buf_out_arm) begin
            m_out_ack   = 1'b1;
            m_out_phase = 1;
        end
        m_app_q = nq;
        m_app_q_known = nk;

        @(posedge phy_ulpi_clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge phy_ulpi_clk);
        #1;
        model_reset();
        total++; if (buf_in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", buf_in_ready); end
        total++; if (buf_out_hasdata !== 1'b0) begin bad++; $display("FAIL reset_hasdata: got %b want 0", buf_out_hasdata); end
        total++; if (eng_in_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", eng_in_valid); end
        total++; if (eng_out_ready !== 1'b0) begin bad++; $display("FAIL reset_out_ready: got %b want 0", eng_out_ready); end
        total++; if ({buf_in_commit_ack, buf_out_arm_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks: got %b want 00", {buf_in_commit_ack, buf_out_arm_ack}); end
        total++; if ({eng_in_len, buf_out_len} !== 20'd0) begin bad++; $display("FAIL reset_lens: got %h want 0", {eng_in_len, buf_out_len}); end
        total++; if ({eng_in_rd_q, buf_out_q} !== 16'd0) begin bad++; $display("FAIL reset_q: got %h want 0", {eng_in_rd_q, buf_out_q}); end
        total++; if (reset_n_out !== 1'b0) begin bad++; $display("FAIL reset_out_low: got %b want 0", reset_n_out); end
        @(negedge phy_ulpi_clk);
        reset_n = 1'b1;
        cycle();
        total++; if (reset_n_out !== 1'b0) begin bad++; $display("FAIL rstout_1clk: got %b want 0", reset_n_out); end
        cycle();
        total++; if (reset_n_out !== 1'b1) begin bad++; $display("FAIL rstout_2clk: got %b want 1", reset_n_out); end
        $display("reset: ready=%b rst_out=%b", buf_in_ready, reset_n_out);
    endtask

    task automatic test_in_commit();
        buf_in_wren = 1; buf_in_addr = 9'd0; buf_in_data = 8'hA5;
        cycle();
        buf_in_addr = 9'd1; buf_in_data = 8'h3C;
        cycle();
        buf_in_wren = 0; buf_in_commit = 1; buf_in_commit_len = 10'd2;
        cycle();
        buf_in_commit = 0;
        total++; if (buf_in_commit_ack !== 1'b1) begin bad++; $display("FAIL in_ack: got %b want 1", buf_in_commit_ack); end
        total++; if (buf_in_ready !== 1'b0) begin bad++; $display("FAIL in_ready_full: got %b want 0", buf_in_ready); end
        total++; if (eng_in_valid !== 1'b1) begin bad++; $display("FAIL in_valid: got %b want 1", eng_in_valid); end
        total++; if (eng_in_len !== 10'd2) begin bad++; $display("FAIL in_len: got %0d want 2", eng_in_len); end
        eng_in_rd_addr = 9'd1;
        cycle();
        total++; if (buf_in_commit_ack !== 1'b0) begin bad++; $display("FAIL in_ack_pulse: got %b want 0", buf_in_commit_ack); end
        total++; if (eng_in_rd_q !== 8'h3C) begin bad++; $display("FAIL in_rd1: got %h want 3c", eng_in_rd_q); end
        $display("in commit: len=%0d rd@1=%h", eng_in_len, eng_in_rd_q);
    endtask

    task automatic test_in_full_ignore();
        buf_in_wren = 1; buf_in_addr = 9'd0; buf_in_data = 8'hFF;
        buf_in_commit = 1; buf_in_commit_len = 10'd5;
        cycle();
        idle_inputs();
        total++; if (buf_in_commit_ack !== 1'b0) begin bad++; $display("FAIL full_no_ack: got %b want 0", buf_in_commit_ack); end
        total++; if (eng_in_len !== 10'd2) begin bad++; $display("FAIL full_len_hold: got %0d want 2", eng_in_len); end
        eng_in_rd_addr = 9'd0;
        cycle();
        total++; if (eng_in_rd_q !== 8'hA5) begin bad++; $display("FAIL full_rd0: got %h want a5", eng_in_rd_q); end
        eng_in_done = 1;
        cycle();
        eng_in_done = 0;
        total++; if (buf_in_ready !== 1'b1 || eng_in_valid !== 1'b0) begin bad++; $display("FAIL done_release: got ready=%b valid=%b want 1 0", buf_in_ready, eng_in_valid); end
        eng_in_done = 1;
        cycle();
        eng_in_done = 0;
        total++; if (buf_in_ready !== 1'b1) begin bad++; $display("FAIL done_idle: got %b want 1", buf_in_ready); end
        buf_in_commit = 1; buf_in_commit_len = 10'd0;
        cycle();
        buf_in_commit = 0;
        total++; if (eng_in_valid !== 1'b1 || eng_in_len !== 10'd0) begin bad++; $display("FAIL zlp: got valid=%b len=%0d want 1 0", eng_in_valid, eng_in_len); end
        eng_in_done = 1;
        cycle();
        eng_in_done = 0;
        $display("in full: rd@0=%h ready=%b", eng_in_rd_q, buf_in_ready);
    endtask

    task automatic test_out_fill();
        buf_out_arm = 1;
        cycle();
        buf_out_arm = 0;
        total++; if (buf_out_arm_ack !== 1'b1) begin bad++; $display("FAIL arm_ack: got %b want 1", buf_out_arm_ack); end
        total++; if (eng_out_ready !== 1'b1) begin bad++; $display("FAIL arm_ready: got %b want 1", eng_out_ready); end
        eng_out_wren = 1; eng_out_wr_addr = 9'd0; eng_out_wr_data = 8'h11;
        cycle();
        total++; if (buf_out_arm_ack !== 1'b0) begin bad++; $display("FAIL arm_ack_pulse: got %b want 0", buf_out_arm_ack); end
        eng_out_wr_addr = 9'd511; eng_out_wr_data = 8'h22;
        cycle();
        eng_out_wren = 0; eng_out_commit = 1; eng_out_commit_len = 10'd512;
        cycle();
        eng_out_commit = 0;
        total++; if (buf_out_hasdata !== 1'b1 || eng_out_ready !== 1'b0) begin bad++; $display("FAIL out_full: got hasdata=%b ready=%b want 1 0", buf_out_hasdata, eng_out_ready); end
        total++; if (buf_out_len !== 10'd512) begin bad++; $display("FAIL out_len512: got %0d want 512", buf_out_len); end
        buf_out_addr = 9'd511;
        cycle();
        total++; if (buf_out_q !== 8'h22) begin bad++; $display("FAIL out_rd511: got %h want 22", buf_out_q); end
        eng_out_wren = 1; eng_out_wr_addr = 9'd0; eng_out_wr_data = 8'h77;
        cycle();
        eng_out_wren = 0; buf_out_addr = 9'd0;
        cycle();
        total++; if (buf_out_q !== 8'h11) begin bad++; $display("FAIL out_wr_ignored: got %h want 11", buf_out_q); end
        $display("out fill: len=%0d rd@0=%h", buf_out_len, buf_out_q);
    endtask

    task automatic test_out_release();
        buf_out_arm = 1;
        cycle();
        buf_out_arm = 0;
        total++; if (buf_out_hasdata !== 1'b0 || buf_out_arm_ack !== 1'b1) begin bad++; $display("FAIL release: got hasdata=%b ack=%b want 0 1", buf_out_hasdata, buf_out_arm_ack); end
        total++; if (buf_out_len !== 10'd512) begin bad++; $display("FAIL release_len_hold: got %0d want 512", buf_out_len); end
        buf_out_arm = 1;
        cycle();
        buf_out_arm = 0;
        total++; if (buf_out_arm_ack !== 1'b1 || eng_out_ready !== 1'b1) begin bad++; $display("FAIL rearm: got ack=%b ready=%b want 1 1", buf_out_arm_ack, eng_out_ready); end
        buf_out_arm = 1; eng_out_commit = 1; eng_out_commit_len = 10'd7;
        cycle();
        buf_out_arm = 0; eng_out_commit = 0;
        total++; if (buf_out_hasdata !== 1'b1 || buf_out_arm_ack !== 1'b0) begin bad++; $display("FAIL arm_commit: got hasdata=%b ack=%b want 1 0", buf_out_hasdata, buf_out_arm_ack); end
        total++; if (buf_out_len !== 10'd7) begin bad++; $display("FAIL arm_commit_len: got %0d want 7", buf_out_len); end
        buf_out_arm = 1;
        cycle();
        buf_out_arm = 0; eng_out_commit = 1; eng_out_commit_len = 10'd600;
        cycle();
        eng_out_commit = 0;
        total++; if (buf_out_len !== 10'd512) begin bad++; $display("FAIL clamp600: got %0d want 512", buf_out_len); end
        $display("out release: len=%0d hasdata=%b", buf_out_len, buf_out_hasdata);
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = bad;
        for (int n = 0; n < 400; n++) begin
            buf_in_wren        = ($urandom_range(0, 1) == 1);
            buf_in_addr        = 9'($urandom_range(0, 7));
            buf_in_data        = 8'($urandom);
            buf_in_commit      = ($urandom_range(0, 7) == 0);
            buf_in_commit_len  = 10'($urandom);
            eng_in_rd_addr     = 9'($urandom_range(0, 7));
            eng_in_done        = ($urandom_range(0, 5) == 0);
            buf_out_addr       = 9'($urandom_range(0, 7));
            buf_out_arm        = ($urandom_range(0, 5) == 0);
            eng_out_wren       = ($urandom_range(0, 1) == 1);
            eng_out_wr_addr    = 9'($urandom_range(0, 7));
            eng_out_wr_data    = 8'($urandom);
            eng_out_commit     = ($urandom_range(0, 6) == 0);
            eng_out_commit_len = 10'($urandom);
            cycle();
            total++; if (buf_in_ready !== m_app_owns_in || eng_in_valid !== !m_app_owns_in) begin bad++; $display("FAIL rnd_in_own n=%0d: got ready=%b valid=%b want ready=%b", n, buf_in_ready, eng_in_valid, m_app_owns_in); end
            total++; if (buf_in_commit_ack !== m_in_ack) begin bad++; $display("FAIL rnd_in_ack n=%0d: got %b want %b", n, buf_in_commit_ack, m_in_ack); end
            total++; if (eng_in_len !== m_in_len) begin bad++; $display("FAIL rnd_in_len n=%0d: got %0d want %0d", n, eng_in_len, m_in_len); end
            total++; if (eng_out_ready !== (m_out_phase == 1) || buf_out_hasdata !== (m_out_phase == 2)) begin bad++; $display("FAIL rnd_out_phase n=%0d: got ready=%b hasdata=%b want phase %0d", n, eng_out_ready, buf_out_hasdata, m_out_phase); end
            total++; if (buf_out_arm_ack !== m_out_ack) begin bad++; $display("FAIL rnd_out_ack n=%0d: got %b want %b", n, buf_out_arm_ack, m_out_ack); end
            total++; if (buf_out_len !== m_out_len) begin bad++; $display("FAIL rnd_out_len n=%0d: got %0d want %0d", n, buf_out_len, m_out_len); end
            if (m_eng_q_known) begin
                total++; if (eng_in_rd_q !== m_eng_q) begin bad++; $display("FAIL rnd_eng_q n=%0d: got %h want %h", n, eng_in_rd_q, m_eng_q); end
            end
            if (m_app_q_known) begin
                total++; if (buf_out_q !== m_app_q) begin bad++; $display("FAIL rnd_app_q n=%0d: got %h want %h", n, buf_out_q, m_app_q); end
            end
        end
        idle_inputs();
        $display("random: 400 cycles, new errors=%0d", bad - errs_before);
    endtask

    task automatic test_midreset();
        buf_in_commit = 1; buf_in_commit_len = 10'd9; buf_out_arm = 1;
        cycle();
        idle_inputs();
        eng_out_commit = 1; eng_out_commit_len = 10'd4;
        cycle();
        idle_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (buf_in_ready !== 1'b1 || eng_in_valid !== 1'b0) begin bad++; $display("FAIL midrst_in: got ready=%b valid=%b want 1 0", buf_in_ready, eng_in_valid); end
        total++; if (buf_out_hasdata !== 1'b0 || eng_out_ready !== 1'b0 || buf_out_len !== 10'd0 || eng_in_len !== 10'd0) begin bad++; $display("FAIL midrst_out: got hasdata=%b ready=%b len=%0d inlen=%0d want 0 0 0 0", buf_out_hasdata, eng_out_ready, buf_out_len, eng_in_len); end
        total++; if (reset_n_out !== 1'b0) begin bad++; $display("FAIL midrst_rstout: got %b want 0", reset_n_out); end
        model_reset();
        @(negedge phy_ulpi_clk);
        reset_n = 1'b1;
        cycle();
        cycle();
        total++; if (reset_n_out !== 1'b1 || buf_in_ready !== 1'b1) begin bad++; $display("FAIL midrst_recover: got rst_out=%b ready=%b want 1 1", reset_n_out, buf_in_ready); end
        $display("mid reset: ready=%b rst_out=%b", buf_in_ready, reset_n_out);
    endtask

    initial begin
        test_reset();
        test_in_commit();
        test_in_full_ignore();
        test_out_fill();
        test_out_release();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
